// File: rtl/phase_step_sequencer.sv
// phase_step_sequencer
//
// Purpose: steps the phase code of a high-frequency modulation clock
// generator through a programmable sequence. Each step settles for
// SETTLE_CYCLES+1 cycles, exposes for HOLD_CYCLES+1 cycles, then spends one
// NEXT cycle advancing the phase. All sequence settings are captured into
// shadow registers when a sequence starts, so the inputs may change freely
// while BUSY is high.
//
// Ports:
//   CLK_IN        sole clock, rising edge
//   RST           synchronous active-high reset (highest priority)
//   START         begin a sequence (IDLE only, ignored together with STOP)
//   STOP          abort to IDLE from any state
//   PHASE_START   first phase code
//   PHASE_INC     phase increment per step (mod 32)
//   NUM_STEPS     steps per sequence, 0 encodes 32
//   SETTLE_CYCLES settle length minus one
//   HOLD_CYCLES   exposure length minus one
//   FREQ_SEL_IN   frequency code applied for the sequence
//   DUTY_SEL_IN   duty code applied for the sequence
//   LOOP          restart from PHASE_START after the last step
//   FREQ_SEL, PHASE_SEL, DUTY_SEL  registered codes to the clock generator
//   EXPOSE        exposure window
//   BUSY          sequence active
//   STEP_IDX      current step index
//   STEP_DONE     one-cycle pulse in the NEXT cycle of every step
//   SEQ_DONE      one-cycle pulse in the NEXT cycle of the last step
//
// States:
//   state    | meaning
//   S_IDLE   | waiting for START, code outputs hold their last values
//   S_SETTLE | generator settling on the new phase, EXPOSE low
//   S_EXPOSE | exposure window, EXPOSE high
//   S_NEXT   | one-cycle step boundary, STEP_DONE high, phase advances
module phase_step_sequencer #(
  parameter int HOLD_W = 16
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic [4:0]        PHASE_START,
  input  logic [4:0]        PHASE_INC,
  input  logic [4:0]        NUM_STEPS,
  input  logic [7:0]        SETTLE_CYCLES,
  input  logic [HOLD_W-1:0] HOLD_CYCLES,
  input  logic [2:0]        FREQ_SEL_IN,
  input  logic [3:0]        DUTY_SEL_IN,
  input  logic              LOOP,
  output logic [2:0]        FREQ_SEL,
  output logic [4:0]        PHASE_SEL,
  output logic [3:0]        DUTY_SEL,
  output logic              EXPOSE,
  output logic              BUSY,
  output logic [4:0]        STEP_IDX,
  output logic              STEP_DONE,
  output logic              SEQ_DONE
);

  // One down-counter serves both the settle and the hold interval.
  localparam int CNT_W = (HOLD_W > 8) ? HOLD_W : 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EXPOSE,
    S_NEXT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic [4:0]        phase_start_q;
  logic [4:0]        phase_inc_q;
  logic [4:0]        num_steps_q;
  logic [7:0]        settle_q;
  logic [HOLD_W-1:0] hold_q;
  logic              loop_q;

  // NUM_STEPS=0 wraps to 31 here, which is exactly the last index of a
  // 32-step sequence.
  logic [4:0]        last_idx;
  logic              last_step;

  assign last_idx  = num_steps_q - 5'd1;
  assign last_step = (STEP_IDX == last_idx);

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      phase_start_q <= '0;
      phase_inc_q   <= '0;
      num_steps_q   <= '0;
      settle_q      <= '0;
      hold_q        <= '0;
      loop_q        <= 1'b0;
      FREQ_SEL      <= '0;
      PHASE_SEL     <= '0;
      DUTY_SEL      <= '0;
      STEP_IDX      <= '0;
      EXPOSE        <= 1'b0;
      BUSY          <= 1'b0;
      STEP_DONE     <= 1'b0;
      SEQ_DONE      <= 1'b0;
    end else if (STOP) begin
      // Abort: code outputs and STEP_IDX are left as they are.
      state     <= S_IDLE;
      cnt       <= '0;
      EXPOSE    <= 1'b0;
      BUSY      <= 1'b0;
      STEP_DONE <= 1'b0;
      SEQ_DONE  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            phase_start_q <= PHASE_START;
            phase_inc_q   <= PHASE_INC;
            num_steps_q   <= NUM_STEPS;
            settle_q      <= SETTLE_CYCLES;
            hold_q        <= HOLD_CYCLES;
            loop_q        <= LOOP;
            FREQ_SEL      <= FREQ_SEL_IN;
            DUTY_SEL      <= DUTY_SEL_IN;
            PHASE_SEL     <= PHASE_START;
            STEP_IDX      <= '0;
            cnt           <= CNT_W'(SETTLE_CYCLES);
            BUSY          <= 1'b1;
            state         <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (cnt == '0) begin
            cnt    <= CNT_W'(hold_q);
            EXPOSE <= 1'b1;
            state  <= S_EXPOSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_EXPOSE: begin
          if (cnt == '0) begin
            EXPOSE    <= 1'b0;
            STEP_DONE <= 1'b1;
            SEQ_DONE  <= last_step;
            state     <= S_NEXT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_NEXT: begin
          STEP_DONE <= 1'b0;
          SEQ_DONE  <= 1'b0;
          cnt       <= CNT_W'(settle_q);
          if (!last_step) begin
            PHASE_SEL <= PHASE_SEL + phase_inc_q;
            STEP_IDX  <= STEP_IDX + 5'd1;
            state     <= S_SETTLE;
          end else if (loop_q) begin
            PHASE_SEL <= phase_start_q;
            STEP_IDX  <= '0;
            state     <= S_SETTLE;
          end else begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state  <= S_IDLE;
          BUSY   <= 1'b0;
          EXPOSE <= 1'b0;
        end
      endcase
    end
  end

endmodule
